lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store control stage sitting directly upstream of the byte-addressable data memory.
- Accepts one memory request at a time from the execute stage over a valid/ready handshake, and decodes the RISC-V funct3 into access size and signedness.
- Range-checks the address, drives the data memory port for exactly one cycle, and returns a registered response (load data or store acknowledge) to writeback over a second valid/ready handshake.

Parameters:
- MEM_BYTES, 1048576, size of data memory in bytes; accesses touching any byte at address >= MEM_BYTES fault.
- CNT_WIDTH, 32, width of the load/store performance counters.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_is_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I load/store funct3
- req_addr  input  32  effective byte address
- req_wdata  input  32  store data (low bytes used for SB/SH)
- req_rd  input  5  destination register tag, returned unchanged
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  32  extended load data; 0 for stores and faults
- resp_rd  output  5  echoed tag
- resp_is_store  output  1  echoed request type
- resp_fault  output  1  illegal funct3, out-of-range, or (optionally) misaligned
- mem_address  output  32  to data memory
- mem_data_in  output  32  to data memory
- mem_read_write  output  1  0 read, 1 write
- mem_access_size  output  2  00 byte, 01 half, 10 word
- mem_is_signed  output  1  sign-extend loads
- mem_data_out  input  32  combinational read data from data memory
- load_count  output  CNT_WIDTH  completed non-faulting loads
- store_count  output  CNT_WIDTH  completed non-faulting stores

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset (async) forces IDLE.
- Reset values: resp_valid=0, resp_rdata=0, resp_rd=0, resp_is_store=0, resp_fault=0, counters=0.
- req_ready=1 only in IDLE.
- mem_read_write is combinationally 0 whenever reset=1 or state!=ACCESS. A store caught in ACCESS by reset is never committed.
- IDLE: on req_valid&&req_ready, register all req_* fields and go to ACCESS.
- Decode:
  - load funct3: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned.
  - store funct3: 000, 001, 010.
  - Anything else is illegal.
- Range check: addr + bytes - 1 >= MEM_BYTES faults. The sum is computed in 33 bits so wrap at 0xFFFFFFFF also faults.
- ACCESS (exactly 1 cycle):
  - If not faulting, drive mem_address=addr, mem_access_size, mem_is_signed, mem_data_in=wdata, mem_read_write=is_store.
  - Load: capture mem_data_out into resp_rdata at the cycle's end.
  - Store: the write commits at that same clock edge.
  - Faulting: mem_read_write=0, resp_rdata=0, resp_fault=1.
  - Always go to RESP with resp_valid=1.
  - Increment load_count or store_count at this edge only if not faulting; counters wrap modulo 2^CNT_WIDTH.
- Idle port values: outside ACCESS, mem_address=0, mem_data_in=0, mem_access_size=2'b10, mem_is_signed=0.
- RESP: hold all resp_* stable while resp_valid&&!resp_ready. On resp_ready, clear resp_valid and return to IDLE.
- Latency and throughput: request accept to resp_valid is 2 cycles; minimum 3 cycles per request.
- req_valid asserted outside IDLE is ignored; the requester holds it until accepted.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: halfword with addr[0]!=0, or word with addr[1:0]!=0, is treated as a fault. No memory access occurs, resp_fault=1, counters unchanged.
- Undefined: misaligned accesses pass to memory unchanged; the memory handles any byte alignment.

Test Plan:
- Store then load: SW addr 0x100 data 0xDEADBEEF, then LW 0x100 -> resp_rdata=0xDEADBEEF, resp_fault=0, store_count=1, load_count=1.
- Sign/zero extension: SB 0x200 data 0x80, then LB 0x200 -> 0xFFFFFF80; LBU 0x200 -> 0x00000080; SH 0x204 0x8001, then LH -> 0xFFFF8001, LHU -> 0x00008001.
- Range fault: LW 0x000FFFFE (MEM_BYTES default) -> resp_fault=1, rdata=0, mem_read_write never 1, load_count unchanged; LW 0xFFFFFFFE -> fault.
- Illegal funct3: store funct3=100 at 0x10 -> fault response, memory byte 0x10 unchanged.
- Backpressure and reset: hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0. Assert reset during ACCESS of SW 0x300 0x12345678 -> word at 0x300 unchanged, resp_valid=0, FSM in IDLE.
- Misalignment: LW 0x101 -> fault with LSU_MISALIGN_TRAP_EN; with the macro undefined -> bytes 0x101..0x104 returned, no fault.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store control stage: one request at a time, funct3 decode, range check,
// single-cycle data memory access and registered response. Optional macro: LSU_MISALIGN_TRAP_EN.
module lsu_ctrl #(
    parameter int unsigned MEM_BYTES = 1048576,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    // Both handshakes: a transfer happens on a rising edge where valid && ready;
    // valid is never withdrawn before that edge and ready never depends on valid.
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_is_store,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [4:0]           req_rd,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic [4:0]           resp_rd,
    output logic                 resp_is_store,
    output logic                 resp_fault,
    output logic [31:0]          mem_address,
    output logic [31:0]          mem_data_in,
    output logic                 mem_read_write,
    output logic [1:0]           mem_access_size,
    output logic                 mem_is_signed,
    input  logic [31:0]          mem_data_out,
    output logic [CNT_WIDTH-1:0] load_count,
    output logic [CNT_WIDTH-1:0] store_count,
    output logic [1:0]           dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    logic [1:0]           state_q, state_d;
    logic                 is_store_q, is_store_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [4:0]           rd_q, rd_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [31:0]          resp_rdata_q, resp_rdata_d;
    logic [4:0]           resp_rd_q, resp_rd_d;
    logic                 resp_is_store_q, resp_is_store_d;
    logic                 resp_fault_q, resp_fault_d;
    logic [CNT_WIDTH-1:0] load_count_q, load_count_d;
    logic [CNT_WIDTH-1:0] store_count_q, store_count_d;

    logic        dec_legal;
    logic [1:0]  dec_size;
    logic        dec_signed;
    logic [32:0] last_off;
    logic        range_fault;
    logic        misalign;
    logic        fault;
    logic        do_access;
    logic [31:0] load_ext;

    always_comb begin
        dec_legal  = 1'b0;
        dec_size   = 2'b10;
        dec_signed = 1'b0;
        case (funct3_q)
            3'b000: begin dec_legal = 1'b1;          dec_size = 2'b00; dec_signed = !is_store_q; end
            3'b001: begin dec_legal = 1'b1;          dec_size = 2'b01; dec_signed = !is_store_q; end
            3'b010: begin dec_legal = 1'b1;          dec_size = 2'b10; end
            3'b100: begin dec_legal = !is_store_q;   dec_size = 2'b00; end
            3'b101: begin dec_legal = !is_store_q;   dec_size = 2'b01; end
            default: begin dec_legal = 1'b0; end
        endcase
    end

    // Last touched byte computed in 33 bits so a wrap past 0xFFFFFFFF still faults.
    always_comb begin
        case (dec_size)
            2'b00:   last_off = 33'd0;
            2'b01:   last_off = 33'd1;
            default: last_off = 33'd3;
        endcase
        range_fault = (({1'b0, addr_q} + last_off) >= MEM_LIMIT);
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((dec_size == 2'b01) && addr_q[0]) ||
                      ((dec_size == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign fault     = !dec_legal || range_fault || misalign;
    assign do_access = (state_q == S_ACCESS) && !fault;

    assign mem_address     = do_access ? addr_q : 32'd0;
    assign mem_data_in     = do_access ? wdata_q : 32'd0;
    assign mem_access_size = do_access ? dec_size : 2'b10;
    assign mem_is_signed   = do_access ? dec_signed : 1'b0;
    assign mem_read_write  = do_access && is_store_q && !reset;

    // Re-extend locally so the result is right whether or not the memory extends.
    always_comb begin
        case (dec_size)
            2'b00:   load_ext = dec_signed ? {{24{mem_data_out[7]}}, mem_data_out[7:0]}
                                           : {24'd0, mem_data_out[7:0]};
            2'b01:   load_ext = dec_signed ? {{16{mem_data_out[15]}}, mem_data_out[15:0]}
                                           : {16'd0, mem_data_out[15:0]};
            default: load_ext = mem_data_out;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        is_store_d      = is_store_q;
        funct3_d        = funct3_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rd_d            = rd_q;
        resp_valid_d    = resp_valid_q;
        resp_rdata_d    = resp_rdata_q;
        resp_rd_d       = resp_rd_q;
        resp_is_store_d = resp_is_store_q;
        resp_fault_d    = resp_fault_q;
        load_count_d    = load_count_q;
        store_count_d   = store_count_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    is_store_d = req_is_store;
                    funct3_d   = req_funct3;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    rd_d       = req_rd;
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d         = S_RESP;
                resp_valid_d    = 1'b1;
                resp_rd_d       = rd_q;
                resp_is_store_d = is_store_q;
                resp_fault_d    = fault;
                resp_rdata_d    = (fault || is_store_q) ? 32'd0 : load_ext;
                if (!fault && is_store_q)  store_count_d = store_count_q + CNT_WIDTH'(1);
                if (!fault && !is_store_q) load_count_d  = load_count_q + CNT_WIDTH'(1);
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            is_store_q      <= 1'b0;
            funct3_q        <= 3'd0;
            addr_q          <= 32'd0;
            wdata_q         <= 32'd0;
            rd_q            <= 5'd0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'd0;
            resp_rd_q       <= 5'd0;
            resp_is_store_q <= 1'b0;
            resp_fault_q    <= 1'b0;
            load_count_q    <= '0;
            store_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            is_store_q      <= is_store_d;
            funct3_q        <= funct3_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            rd_q            <= rd_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_rd_q       <= resp_rd_d;
            resp_is_store_q <= resp_is_store_d;
            resp_fault_q    <= resp_fault_d;
            load_count_q    <= load_count_d;
            store_count_q   <= store_count_d;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_rd       = resp_rd_q;
    assign resp_is_store = resp_is_store_q;
    assign resp_fault    = resp_fault_q;
    assign load_count    = load_count_q;
    assign store_count   = store_count_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array data memory, reference model built on a sparse
// byte map, directed cases followed by randomized requests.
module tb_lsu_ctrl;

    localparam int MEMB = 1048576;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_is_store;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read_write;
    logic [1:0]  mem_access_size;
    logic        mem_is_signed;
    logic [31:0] mem_data_out = 32'd0;
    logic [31:0] load_count;
    logic [31:0] store_count;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad = 0;

    logic [7:0]  mem [0:MEMB-1];
    bit          init_done = 1'b0;
    int          write_events = 0;
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] exp_loads = 32'd0;
    logic [31:0] exp_stores = 32'd0;

    lsu_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_is_store(resp_is_store), .resp_fault(resp_fault),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_read_write(mem_read_write),
        .mem_access_size(mem_access_size), .mem_is_signed(mem_is_signed),
        .mem_data_out(mem_data_out), .load_count(load_count), .store_count(store_count),
        .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    // Data memory: writes commit on the rising edge, reads settle on the falling edge.
    always @(posedge clock) begin
        if (!init_done) begin
            for (int i = 0; i < MEMB; i++) mem[i] = 8'h00;
            init_done = 1'b1;
        end
        if (mem_read_write) begin
            write_events = write_events + 1;
            for (int i = 0; i < 4; i++) begin
                if (i < (1 << mem_access_size) && (longint'(mem_address) + i) < MEMB)
                    mem[20'(mem_address + 32'(i))] = mem_data_in[8*i +: 8];
            end
        end
    end

    always @(negedge clock) begin
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if ((longint'(mem_address) + i) < MEMB) v[8*i +: 8] = mem[20'(mem_address + 32'(i))];
        end
        case (mem_access_size)
            2'b00:   v = mem_is_signed ? {{24{v[7]}}, v[7:0]} : {24'd0, v[7:0]};
            2'b01:   v = mem_is_signed ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
            default: v = v;
        endcase
        mem_data_out = v;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit ref_fault(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        bit legal;
        int n;
        legal = st ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        n = size_of(f3);
        if (!legal) return 1'b1;
        if (longint'(addr) + n - 1 >= MEMB) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((addr % n) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] v;
        int n;
        n = size_of(f3);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_rd(addr + 32'(i))) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold);
        bit          flt;
        logic [31:0] exp_data;
        logic [4:0]  rd;
        int          w0;
        rd = 5'($urandom_range(0, 31));
        flt = ref_fault(st, f3, addr);
        exp_data = (!st && !flt) ? ref_load(f3, addr) : 32'd0;
        if (st && !flt) exp_stores++;
        if (!st && !flt) exp_loads++;
        w0 = write_events;

        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("req_ready_busy", {31'd0, req_ready}, 32'd0);
        check("resp_valid_early", {31'd0, resp_valid}, 32'd0);
        @(posedge clock); #1;
        check("resp_valid", {31'd0, resp_valid}, 32'd1);
        check("resp_fault", {31'd0, resp_fault}, {31'd0, flt});
        check("resp_rdata", resp_rdata, exp_data);
        check("resp_rd", {27'd0, resp_rd}, {27'd0, rd});
        check("resp_is_store", {31'd0, resp_is_store}, {31'd0, st});
        check("load_count", load_count, exp_loads);
        check("store_count", store_count, exp_stores);
        check("mem_writes", 32'(write_events - w0), (st && !flt) ? 32'd1 : 32'd0);

        if (st && !flt)
            for (int i = 0; i < size_of(f3); i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
        if (st)
            for (int i = 0; i < 4; i++)
                if (longint'(addr) + i < MEMB)
                    check("mem_byte", {24'd0, mem[20'(addr + 32'(i))]}, {24'd0, ref_rd(addr + 32'(i))});

        for (int c = 0; c < hold; c++) begin
            @(posedge clock); #1;
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_rdata", resp_rdata, exp_data);
            check("hold_fault", {31'd0, resp_fault}, {31'd0, flt});
            check("hold_rd", {27'd0, resp_rd}, {27'd0, rd});
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        check("resp_valid_clear", {31'd0, resp_valid}, 32'd0);
        check("req_ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic reset_during_store(input logic [31:0] addr, input logic [31:0] wdata);
        int w0;
        w0 = write_events;
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
        req_addr = addr; req_wdata = wdata; req_rd = 5'd7;
        @(posedge clock); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_mem_rw", {31'd0, mem_read_write}, 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        reset = 1'b0;
        exp_loads = 32'd0;
        exp_stores = 32'd0;
        #1;
        check("rst_no_write", 32'(write_events - w0), 32'd0);
        for (int i = 0; i < 4; i++)
            check("rst_mem_byte", {24'd0, mem[20'(addr + 32'(i))]}, {24'd0, ref_rd(addr + 32'(i))});
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_store_count", store_count, 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        logic        st;
        repeat (3) @(posedge clock);
        #1;
        check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset_resp_rdata", resp_rdata, 32'd0);
        check("reset_resp_rd", {27'd0, resp_rd}, 32'd0);
        check("reset_resp_fault", {31'd0, resp_fault}, 32'd0);
        check("reset_load_count", load_count, 32'd0);
        check("reset_store_count", store_count, 32'd0);
        check("reset_mem_rw", {31'd0, mem_read_write}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;

        do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0);
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 0);
        do_req(1'b1, 3'b000, 32'h200, 32'h80, 1);
        do_req(1'b0, 3'b000, 32'h200, 32'h0, 0);
        do_req(1'b0, 3'b100, 32'h200, 32'h0, 0);
        do_req(1'b1, 3'b001, 32'h204, 32'h8001, 0);
        do_req(1'b0, 3'b001, 32'h204, 32'h0, 2);
        do_req(1'b0, 3'b101, 32'h204, 32'h0, 0);
        do_req(1'b0, 3'b010, 32'h000F_FFFE, 32'h0, 0);
        do_req(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 0);
        do_req(1'b0, 3'b000, 32'h000F_FFFF, 32'h0, 0);
        do_req(1'b1, 3'b100, 32'h10, 32'hA5A5A5A5, 0);
        do_req(1'b0, 3'b010, 32'h101, 32'h0, 5);
        do_req(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 0);
        reset_during_store(32'h300, 32'h12345678);
        do_req(1'b0, 3'b010, 32'h300, 32'h0, 0);

        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 5))
                0:       a = MEMB - 32'($urandom_range(0, 5));
                1:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: a = 32'h100 + 32'($urandom_range(0, 63));
            endcase
            f3 = 3'($urandom_range(0, 7));
            st = 1'($urandom_range(0, 1));
            do_req(st, f3, a, $urandom, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
